// File: rtl/clk_gate_ctrl.sv
// Multi-channel glitch-free clock gating controller: per-channel OFF/WAKE/ON FSM
// with idle auto-gating, wake acknowledge and a scan override on a latch+AND gate.

module clk_gate_ch #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic test_en,
  input  logic en_s,
  input  logic busy_s,
  output logic gclk,
  output logic ack,
  output logic gated
);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);

  typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic [WW-1:0] wake_cnt, wake_nxt;
  logic          ge;
  logic          latch_q;

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    wake_nxt  = wake_cnt;
    case (state)
      S_OFF: begin
        if (en_s && busy_s) begin
          state_nxt = S_WAKE;
          wake_nxt  = '0;
        end
      end
      S_WAKE: begin
        // Wake always runs to completion; inputs are ignored until ON.
        if (wake_cnt == WW'(WAKE_CYCLES - 1)) begin
          state_nxt = S_ON;
          wake_nxt  = '0;
          idle_nxt  = '0;
        end else begin
          wake_nxt = wake_cnt + WW'(1);
        end
      end
      S_ON: begin
        if (busy_s) begin
          idle_nxt = '0;
        end else if (!en_s) begin
          state_nxt = S_OFF;
          idle_nxt  = '0;
        end else if (idle_cnt == IW'(IDLE_CYCLES - 1)) begin
          state_nxt = S_OFF;
          idle_nxt  = '0;
        end else begin
          idle_nxt = idle_cnt + IW'(1);
        end
      end
      default: state_nxt = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_OFF;
      idle_cnt <= '0;
      wake_cnt <= '0;
      ge       <= 1'b0;
      ack      <= 1'b0;
      gated    <= 1'b1;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      wake_cnt <= wake_nxt;
      ge       <= (state_nxt != S_OFF);
      ack      <= (state_nxt == S_ON);
      gated    <= (state_nxt == S_OFF);
    end
  end

  // Latch only follows while clk is low, so the AND can never chop a high phase.
  always_latch begin
    if (!rst_n)
      latch_q <= 1'b0;
    else if (!clk)
      latch_q <= ge | test_en;
  end

  assign gclk = clk & latch_q;

endmodule

module clk_gate_ctrl #(
  parameter int NCH         = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           test_en,
  input  logic [NCH-1:0] en_req,
  input  logic [NCH-1:0] busy,
  output logic [NCH-1:0] gclk,
  output logic [NCH-1:0] ack,
  output logic [NCH-1:0] gated,
  output logic           all_gated
);
  logic [NCH-1:0] en_s, busy_s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign en_s   = en_req;
    assign busy_s = busy;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][NCH-1:0] en_ff, busy_ff;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_ff   <= '0;
        busy_ff <= '0;
      end else begin
        en_ff[0]   <= en_req;
        busy_ff[0] <= busy;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          en_ff[i]   <= en_ff[i-1];
          busy_ff[i] <= busy_ff[i-1];
        end
      end
    end

    assign en_s   = en_ff[SYNC_STAGES-1];
    assign busy_s = busy_ff[SYNC_STAGES-1];
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    clk_gate_ch #(
      .IDLE_CYCLES(IDLE_CYCLES),
      .WAKE_CYCLES(WAKE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .test_en(test_en),
      .en_s   (en_s[c]),
      .busy_s (busy_s[c]),
      .gclk   (gclk[c]),
      .ack    (ack[c]),
      .gated  (gated[c])
    );
  end

  assign all_gated = &gated;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed vector table, mid-wake reset sequence and
// random traffic against a timestamp-based reference model plus a pulse-width monitor.

module tb_clk_gate_ctrl;
  localparam int NCH  = 4;
  localparam int IDLE = 16;
  localparam int WAKE = 2;
  localparam int SYNC = 2;
  localparam int HALF = 5;

  localparam int M_OFF  = 0;
  localparam int M_WAKE = 1;
  localparam int M_ON   = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           test_en = 1'b0;
  logic [NCH-1:0] en_req = '0;
  logic [NCH-1:0] busy = '0;
  logic [NCH-1:0] gclk, ack, gated;
  logic           all_gated;

  clk_gate_ctrl #(
    .NCH(NCH), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .test_en(test_en), .en_req(en_req), .busy(busy),
    .gclk(gclk), .ack(ack), .gated(gated), .all_gated(all_gated)
  );

  always #HALF clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every gclk pulse must start on a clk rising edge and last exactly half a period.
  bit             mon_en = 1'b0;
  logic [NCH-1:0] gclk_prev = '0;
  time            rise_t [NCH];

  always @(gclk) begin
    for (int i = 0; i < NCH; i++) begin
      if (gclk[i] === 1'b1 && gclk_prev[i] !== 1'b1) begin
        rise_t[i] = $time;
        if (mon_en) chk("gclk_rise_phase", 32'($time % (2 * HALF)), HALF);
      end else if (gclk[i] !== 1'b1 && gclk_prev[i] === 1'b1) begin
        if (mon_en) chk("gclk_pulse_width", 32'($time - rise_t[i]), HALF);
      end
    end
    gclk_prev = gclk;
  end

  // Reference model: input delay as a FIFO, dwell measured with edge timestamps.
  int             md       [NCH];
  int             wake_at  [NCH];
  int             last_act [NCH];
  int             e_cnt;
  logic [NCH-1:0] en_q[$], bs_q[$];
  logic [NCH-1:0] open_now, exp_gclk, exp_ack, exp_gated;

  function automatic void model_reset();
    en_q.delete();
    bs_q.delete();
    for (int i = 0; i < SYNC; i++) begin
      en_q.push_back('0);
      bs_q.push_back('0);
    end
    for (int c = 0; c < NCH; c++) begin
      md[c] = M_OFF;
      wake_at[c] = 0;
      last_act[c] = 0;
    end
    e_cnt = 0;
    open_now = '0;
    exp_gclk = '0;
    exp_ack = '0;
    exp_gated = '1;
  endfunction

  function automatic void model_edge(input logic t, input logic [NCH-1:0] e_, input logic [NCH-1:0] b_);
    logic [NCH-1:0] es, bs;
    en_q.push_back(e_);
    bs_q.push_back(b_);
    es = en_q.pop_front();
    bs = bs_q.pop_front();
    exp_gclk = open_now | {NCH{t}};
    for (int c = 0; c < NCH; c++) begin
      if (md[c] == M_OFF) begin
        if (es[c] && bs[c]) begin
          md[c] = M_WAKE;
          wake_at[c] = e_cnt;
        end
      end else if (md[c] == M_WAKE) begin
        if (e_cnt - wake_at[c] == WAKE) begin
          md[c] = M_ON;
          last_act[c] = e_cnt;
        end
      end else begin
        if (bs[c]) last_act[c] = e_cnt;
        else if (!es[c]) md[c] = M_OFF;
        else if (e_cnt - last_act[c] == IDLE) md[c] = M_OFF;
      end
      open_now[c]  = (md[c] != M_OFF);
      exp_ack[c]   = (md[c] == M_ON);
      exp_gated[c] = (md[c] == M_OFF);
    end
    e_cnt++;
  endfunction

  // Called one time unit after a rising edge; drives somewhere inside the cycle.
  task automatic step(input logic t, input logic [NCH-1:0] e_, input logic [NCH-1:0] b_);
    #($urandom_range(0, 7));
    test_en = t;
    en_req  = e_;
    busy    = b_;
    @(posedge clk);
    model_edge(t, e_, b_);
    #1;
    chk("model_ack", ack, exp_ack);
    chk("model_gated", gated, exp_gated);
    chk("model_all_gated", all_gated, &exp_gated);
    chk("model_gclk", gclk, exp_gclk);
  endtask

  task automatic do_reset(input logic t, input logic [NCH-1:0] e_, input logic [NCH-1:0] b_);
    @(posedge clk);
    #2;
    mon_en  = 1'b0;
    rst_n   = 1'b0;
    test_en = t;
    en_req  = e_;
    busy    = b_;
    #1;
    chk("reset_gclk_async", gclk, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gclk", gclk, 0);
    chk("reset_ack", ack, 0);
    chk("reset_gated", gated, 4'hF);
    chk("reset_all_gated", all_gated, 1);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic           te;
    logic [NCH-1:0] en;
    logic [NCH-1:0] bs;
    int             n;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] gated;
  } vec_t;

  vec_t           tbl [16];
  logic [NCH-1:0] re, rb;
  logic           rt;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // te, en, busy, cycles, expected ack, expected gated (after the last cycle)
    tbl[0]  = '{1'b0, 4'h1, 4'h1,  2, 4'h0, 4'hF};
    tbl[1]  = '{1'b0, 4'h1, 4'h1,  1, 4'h0, 4'hE};
    tbl[2]  = '{1'b0, 4'h1, 4'h1,  1, 4'h0, 4'hE};
    tbl[3]  = '{1'b0, 4'h1, 4'h1,  1, 4'h1, 4'hE};
    tbl[4]  = '{1'b0, 4'h1, 4'h0, 16, 4'h1, 4'hE};
    tbl[5]  = '{1'b0, 4'h1, 4'h0,  1, 4'h1, 4'hE};
    tbl[6]  = '{1'b0, 4'h1, 4'h0,  1, 4'h0, 4'hF};
    tbl[7]  = '{1'b0, 4'h0, 4'h0,  3, 4'h0, 4'hF};
    tbl[8]  = '{1'b0, 4'h4, 4'h4,  4, 4'h0, 4'hB};
    tbl[9]  = '{1'b0, 4'h4, 4'h4,  1, 4'h4, 4'hB};
    tbl[10] = '{1'b0, 4'h0, 4'h4,  8, 4'h4, 4'hB};
    tbl[11] = '{1'b0, 4'h0, 4'h0,  2, 4'h4, 4'hB};
    tbl[12] = '{1'b0, 4'h0, 4'h0,  1, 4'h0, 4'hF};
    tbl[13] = '{1'b1, 4'h0, 4'h0,  2, 4'h0, 4'hF};
    tbl[14] = '{1'b0, 4'hF, 4'hF,  3, 4'h0, 4'h0};
    tbl[15] = '{1'b0, 4'hF, 4'hF,  2, 4'hF, 4'h0};

    do_reset(1'b1, '1, '1);

    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < tbl[r].n; k++) step(tbl[r].te, tbl[r].en, tbl[r].bs);
      chk($sformatf("tbl%0d_ack", r), ack, tbl[r].ack);
      chk($sformatf("tbl%0d_gated", r), gated, tbl[r].gated);
      chk($sformatf("tbl%0d_all_gated", r), all_gated, &tbl[r].gated);
    end

    // Reset in the middle of a WAKE high phase, then a full-latency re-wake.
    do_reset(1'b0, '0, '0);
    repeat (4) step(1'b0, 4'h1, 4'h1);
    chk("midwake_gclk_open", gclk[0], 1);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midwake_gclk_drop", gclk, 0);
    chk("midwake_gated", gated, 4'hF);
    chk("midwake_ack", ack, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    model_reset();
    repeat (4) step(1'b0, 4'h1, 4'h1);
    chk("rewake_ack_not_early", ack[0], 0);
    step(1'b0, 4'h1, 4'h1);
    chk("rewake_ack", ack[0], 1);

    // Random traffic with long busy runs so auto-gating and restarts occur.
    do_reset(1'b0, '0, '0);
    re = '1;
    rb = '0;
    rt = 1'b0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 29) == 0) re[c] = ~re[c];
        if ($urandom_range(0, 19) == 0) rb[c] = ~rb[c];
      end
      if ($urandom_range(0, 39) == 0) rt = ~rt;
      step(rt, re, rb);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
